aidc_lite_comp_obuf: RTL and testbench
======================================

Name: aidc_lite_comp_obuf

Overview:
- Stage directly downstream of the AIDC-Lite sign-reduction compressor.
- Captures the compressor's eight 64-bit compressed words per line (written by address) into a two-bank ping-pong buffer.
- On end-of-line, a successful line is committed and streamed out as an 8-beat packet on a valid/ready interface with SOP/EOP.
- A failed (incompressible) line is discarded and flagged, so the line is not forwarded in compressed form.

Parameters:
- STAT_W, 16, width of the optional statistics counters; saturating.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- sr_valid_i  input  1  compressed-word write strobe from compressor; no backpressure.
- sr_addr_i  input  3  word index 0..7 within the line.
- sr_data_i  input  64  compressed word.
- sr_done_i  input  1  compressor idle/done level; 1 after reset; falls at line start, rises at line end.
- sr_fail_i  input  1  line incompressible; valid in the cycle sr_done_i rises.
- m_valid_o  output  1  output beat valid.
- m_ready_i  input  1  downstream accept.
- m_sop_o  output  1  first beat of packet (index 0).
- m_eop_o  output  1  last beat of packet (index 7).
- m_data_o  output  64  beat data.
- line_fail_o  output  1  one-cycle pulse: line discarded due to sr_fail_i.
- ovf_o  output  1  sticky: line dropped because no bank was free; cleared only by reset.
- busy_o  output  1  at least one bank full or a line in capture.
- stat_ok_o  output  STAT_W  committed-line count; optional feature, else 0.
- stat_fail_o  output  STAT_W  failed plus dropped line count; optional feature, else 0.

Behaviour:
- Reset: all outputs 0; wr_sel=0, rd_sel=0, both full flags 0, drop flag 0, capture flag 0. Registered done_q=1. Bank storage is not reset.
- Edge detection: done_q registers sr_done_i.
  - Line start = done_q & ~sr_done_i.
  - Line end (commit) = ~done_q & sr_done_i.
- Line start:
  - Capture flag is set.
  - If full[wr_sel]=1, the drop flag is set for this line.
  - A bank freed by a final read handshake in the same cycle still counts as full, so the line is dropped.
- Writes: on sr_valid_i with capture active and drop=0, sr_data_i is written to bank[wr_sel][sr_addr_i]. The word at addr 7 arrives in the same cycle as the commit and must be written.
- Commit (same cycle as the addr-7 write): capture flag is cleared, and exactly one of the following occurs:
  - drop=1: ovf_o is set and drop is cleared; line_fail_o stays 0.
  - drop=0, sr_fail_i=1: line_fail_o pulses for the next cycle; bank is not marked full; wr_sel is unchanged.
  - drop=0, sr_fail_i=0: full[wr_sel] is set and wr_sel toggles.
- sr_valid_i outside capture is ignored.
- Read FSM has two states, IDLE and SEND, with a 3-bit beat counter.
  - IDLE -> SEND when full[rd_sel]=1; counter=0.
  - SEND: m_valid_o=1, m_data_o=bank[rd_sel][cnt], m_sop_o=(cnt==0), m_eop_o=(cnt==7).
  - On m_valid_o & m_ready_i: cnt increments.
  - At cnt==7 handshake: full[rd_sel] is cleared, rd_sel toggles, counter wraps to 0. Next state is SEND if the other bank is full (zero-bubble), else IDLE.
- Output hold: while m_valid_o=1 and m_ready_i=0, m_data_o, m_sop_o and m_eop_o hold stable. There is no combinational path from m_ready_i to m_valid_o.
- Latency: commit sampled at edge T; m_valid_o for beat 0 is asserted after edge T+1 at the earliest (bank idle). With m_ready_i=1, 8 consecutive beats follow.
- Simultaneous events: commit into one bank in the same cycle as the final handshake of the other bank is legal; both updates take effect.
- Reset mid-operation: everything returns to reset values; any partially captured or partially drained line is lost. The first line after reset is handled normally.

Optional Feature:
- Macro: AIDC_LITE_COMP_OBUF_STAT_EN.
- Defined:
  - stat_ok_o increments on each committed line.
  - stat_fail_o increments on each line_fail_o pulse or each drop.
  - Both counters saturate at 2^STAT_W-1 and reset to 0.
- Undefined: counters are not instantiated and both outputs are tied to 0.

Test Plan:
- Single line, m_ready_i=1: addr 0..7 with data 64'h8000_0000_0000_0000+addr, sr_fail_i=0 -> 8 beats, sop at beat 0, eop at beat 7, data matches by index, beat 0 one cycle after commit.
- Failed line: same writes, sr_fail_i=1 at done rise -> line_fail_o pulses exactly one cycle, m_valid_o stays 0, wr_sel unchanged.
- Backpressure: m_ready_i toggles 1,0,0,1 repeatedly -> data, sop and eop stable during stalls; exactly 8 handshakes per packet, in order.
- Overflow: m_ready_i=0, three back-to-back good lines (A, B, C) -> A and B buffered, C dropped, ovf_o=1. After m_ready_i=1, A then B stream out with no bubble between packets.
- Reset mid-drain: assert rst_n=0 at beat 3 -> all outputs 0 asynchronously; after release, a fresh line streams correctly from index 0.
- With AIDC_LITE_COMP_OBUF_STAT_EN defined: 2 good lines, 1 failed, 1 dropped -> stat_ok_o=2, stat_fail_o=2. Without the macro -> both 0.

Source files
------------

// File: rtl/aidc_lite_comp_obuf.sv
// Ping-pong output buffer behind the AIDC-Lite compressor: captures 8-word lines, streams them as 8-beat packets.
// Optional saturating line statistics are enabled with `define AIDC_LITE_COMP_OBUF_STAT_EN.
module aidc_lite_comp_obuf #(
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sr_valid_i,
   input  logic [2:0]        sr_addr_i,
   input  logic [63:0]       sr_data_i,
   input  logic              sr_done_i,
   input  logic              sr_fail_i,
   output logic              m_valid_o,
   input  logic              m_ready_i,
   output logic              m_sop_o,
   output logic              m_eop_o,
   output logic [63:0]       m_data_o,
   output logic              line_fail_o,
   output logic              ovf_o,
   output logic              busy_o,
   output logic [STAT_W-1:0] stat_ok_o,
   output logic [STAT_W-1:0] stat_fail_o
);

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_SEND = 1'b1
   } rd_state_e;

   // Line-capture state
   logic       done_q;
   logic       cap_q, cap_d;
   logic       drop_q, drop_d;
   logic       wr_sel_q, wr_sel_d;
   logic [1:0] full_q, full_d;
   logic       ovf_q, ovf_d;
   logic       line_fail_q, line_fail_d;

   // Read-side state
   rd_state_e  rd_state_q, rd_state_d;
   logic       rd_sel_q, rd_sel_d;
   logic [2:0] cnt_q, cnt_d;

   logic [63:0] bank_q [2][8];

   logic line_start;
   logic line_end;
   logic wr_en;
   logic commit_ok;
   logic commit_fail;
   logic commit_drop;
   logic send;
   logic beat_hs;
   logic last_hs;

   assign line_start  = done_q & ~sr_done_i;
   assign line_end    = ~done_q & sr_done_i & cap_q;
   assign wr_en       = sr_valid_i & cap_q & ~drop_q;
   assign commit_ok   = line_end & ~drop_q & ~sr_fail_i;
   assign commit_fail = line_end & ~drop_q & sr_fail_i;
   assign commit_drop = line_end & drop_q;

   assign send    = (rd_state_q == RD_SEND);
   assign beat_hs = send & m_ready_i;
   assign last_hs = beat_hs & (cnt_q == 3'd7);

   // NOTE: every always_comb variable gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      cap_d       = cap_q;
      drop_d      = drop_q;
      wr_sel_d    = wr_sel_q;
      full_d      = full_q;
      ovf_d       = ovf_q;
      line_fail_d = 1'b0;

      // full_q is the pre-edge value, so a bank being freed this cycle still forces a drop.
      if (line_start) begin
         cap_d = 1'b1;
         if (full_q[wr_sel_q]) begin
            drop_d = 1'b1;
         end
      end

      if (line_end) begin
         cap_d = 1'b0;
      end

      if (commit_drop) begin
         ovf_d  = 1'b1;
         drop_d = 1'b0;
      end

      if (commit_fail) begin
         line_fail_d = 1'b1;
      end

      if (last_hs) begin
         full_d[rd_sel_q] = 1'b0;
      end

      // Commit targets the write bank, never the bank being drained, so both updates coexist.
      if (commit_ok) begin
         full_d[wr_sel_q] = 1'b1;
         wr_sel_d         = ~wr_sel_q;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_sel_d   = rd_sel_q;
      cnt_d      = cnt_q;

      unique case (rd_state_q)
         RD_IDLE: begin
            if (full_q[rd_sel_q]) begin
               rd_state_d = RD_SEND;
               cnt_d      = 3'd0;
            end
         end
         RD_SEND: begin
            if (beat_hs) begin
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd7) begin
                  rd_sel_d   = ~rd_sel_q;
                  rd_state_d = full_q[~rd_sel_q] ? RD_SEND : RD_IDLE;
               end
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_q      <= 1'b1;
         cap_q       <= 1'b0;
         drop_q      <= 1'b0;
         wr_sel_q    <= 1'b0;
         full_q      <= 2'b00;
         ovf_q       <= 1'b0;
         line_fail_q <= 1'b0;
         rd_state_q  <= RD_IDLE;
         rd_sel_q    <= 1'b0;
         cnt_q       <= 3'd0;
      end else begin
         done_q      <= sr_done_i;
         cap_q       <= cap_d;
         drop_q      <= drop_d;
         wr_sel_q    <= wr_sel_d;
         full_q      <= full_d;
         ovf_q       <= ovf_d;
         line_fail_q <= line_fail_d;
         rd_state_q  <= rd_state_d;
         rd_sel_q    <= rd_sel_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: bank storage has no reset; full flags guard every read, so stale contents are never emitted.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         bank_q[wr_sel_q][sr_addr_i] <= sr_data_i;
      end
   end

   // Outputs are decoded from registered state only, so m_ready_i never reaches m_valid_o.
   assign m_valid_o   = send;
   assign m_sop_o     = send & (cnt_q == 3'd0);
   assign m_eop_o     = send & (cnt_q == 3'd7);
   assign m_data_o    = send ? bank_q[rd_sel_q][cnt_q] : 64'd0;
   assign line_fail_o = line_fail_q;
   assign ovf_o       = ovf_q;
   assign busy_o      = (|full_q) | cap_q;

`ifdef AIDC_LITE_COMP_OBUF_STAT_EN
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   logic [STAT_W-1:0] stat_ok_q, stat_ok_d;
   logic [STAT_W-1:0] stat_fail_q, stat_fail_d;

   always_comb begin
      stat_ok_d   = stat_ok_q;
      stat_fail_d = stat_fail_q;
      if (commit_ok && (stat_ok_q != STAT_MAX)) begin
         stat_ok_d = stat_ok_q + 1'b1;
      end
      if ((commit_fail || commit_drop) && (stat_fail_q != STAT_MAX)) begin
         stat_fail_d = stat_fail_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_ok_q   <= '0;
         stat_fail_q <= '0;
      end else begin
         stat_ok_q   <= stat_ok_d;
         stat_fail_q <= stat_fail_d;
      end
   end

   assign stat_ok_o   = stat_ok_q;
   assign stat_fail_o = stat_fail_q;
`else
   assign stat_ok_o   = '0;
   assign stat_fail_o = '0;
`endif

endmodule

// File: tb/tb_aidc_lite_comp_obuf.sv
// Directed self-checking bench for aidc_lite_comp_obuf: single line, failed line, backpressure,
// overflow with zero-bubble drain, reset mid-drain and line statistics.
module tb_aidc_lite_comp_obuf;

   localparam int STAT_W = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              sr_valid_i = 1'b0;
   logic [2:0]        sr_addr_i = 3'd0;
   logic [63:0]       sr_data_i = 64'd0;
   logic              sr_done_i = 1'b1;
   logic              sr_fail_i = 1'b0;
   logic              m_valid_o;
   logic              m_ready_i = 1'b0;
   logic              m_sop_o;
   logic              m_eop_o;
   logic [63:0]       m_data_o;
   logic              line_fail_o;
   logic              ovf_o;
   logic              busy_o;
   logic [STAT_W-1:0] stat_ok_o;
   logic [STAT_W-1:0] stat_fail_o;

   int checks = 0;
   int errors = 0;

   aidc_lite_comp_obuf #(.STAT_W(STAT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sr_valid_i  (sr_valid_i),
      .sr_addr_i   (sr_addr_i),
      .sr_data_i   (sr_data_i),
      .sr_done_i   (sr_done_i),
      .sr_fail_i   (sr_fail_i),
      .m_valid_o   (m_valid_o),
      .m_ready_i   (m_ready_i),
      .m_sop_o     (m_sop_o),
      .m_eop_o     (m_eop_o),
      .m_data_o    (m_data_o),
      .line_fail_o (line_fail_o),
      .ovf_o       (ovf_o),
      .busy_o      (busy_o),
      .stat_ok_o   (stat_ok_o),
      .stat_fail_o (stat_fail_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, got, exp);
      end
   endtask

   // One compressor line: start cycle, addr 0..6, then addr 7 together with the done rise.
   // Returns 1ns after the commit edge.
   task automatic send_line(input logic [63:0] base, input logic fail);
      sr_done_i  = 1'b0;
      sr_valid_i = 1'b0;
      tick();
      for (int a = 0; a < 7; a++) begin
         sr_valid_i = 1'b1;
         sr_addr_i  = 3'(a);
         sr_data_i  = base + 64'(a);
         tick();
      end
      sr_valid_i = 1'b1;
      sr_addr_i  = 3'd7;
      sr_data_i  = base + 64'd7;
      sr_done_i  = 1'b1;
      sr_fail_i  = fail;
      tick();
      sr_valid_i = 1'b0;
      sr_fail_i  = 1'b0;
      sr_addr_i  = 3'd0;
      sr_data_i  = 64'd0;
   endtask

   // Drains npkt packets (base0 then base1), checking order, sop/eop, stall hold and no bubbles.
   task automatic drain_check(input string name, input logic [63:0] base0, input logic [63:0] base1,
                              input int npkt, input bit stall_pattern);
      int          got;
      int          cyc;
      bit          started;
      bit          stall_prev;
      logic [63:0] exp_data;
      logic [63:0] pd;
      logic        ps;
      logic        pe;
      got        = 0;
      cyc        = 0;
      started    = 1'b0;
      stall_prev = 1'b0;
      pd         = 64'd0;
      ps         = 1'b0;
      pe         = 1'b0;
      while (got < npkt * 8 && cyc < 300) begin
         m_ready_i = stall_pattern ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
         if (stall_prev) begin
            checks++;
            if (m_valid_o !== 1'b1 || m_data_o !== pd || m_sop_o !== ps || m_eop_o !== pe) begin
               errors++;
               $display("FAIL %s_hold: got v=%b d=%h s=%b e=%b expected v=1 d=%h s=%b e=%b",
                        name, m_valid_o, m_data_o, m_sop_o, m_eop_o, pd, ps, pe);
            end
         end
         if (m_valid_o === 1'b1) begin
            started  = 1'b1;
            exp_data = ((got / 8 == 0) ? base0 : base1) + 64'(got % 8);
            checks++;
            if (m_data_o !== exp_data || m_sop_o !== (got % 8 == 0) || m_eop_o !== (got % 8 == 7)) begin
               errors++;
               $display("FAIL %s_beat%0d: got d=%h s=%b e=%b expected d=%h s=%b e=%b",
                        name, got, m_data_o, m_sop_o, m_eop_o, exp_data, (got % 8 == 0), (got % 8 == 7));
            end
            stall_prev = !m_ready_i;
            pd = m_data_o;
            ps = m_sop_o;
            pe = m_eop_o;
            if (m_ready_i) got++;
         end else begin
            stall_prev = 1'b0;
            if (started) begin
               errors++;
               checks++;
               $display("FAIL %s_bubble: got m_valid_o=0 expected 1 at beat %0d", name, got);
            end
         end
         tick();
         cyc++;
      end
      checks++;
      if (got != npkt * 8) begin
         errors++;
         $display("FAIL %s_count: got %0d handshakes expected %0d", name, got, npkt * 8);
      end
      chk1({name, "_idle_after"}, m_valid_o, 1'b0);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick();
      tick();
      chk1("rst_valid", m_valid_o, 1'b0);
      chk1("rst_sop", m_sop_o, 1'b0);
      chk1("rst_eop", m_eop_o, 1'b0);
      chk1("rst_fail", line_fail_o, 1'b0);
      chk1("rst_ovf", ovf_o, 1'b0);
      chk1("rst_busy", busy_o, 1'b0);
      checks++;
      if (m_data_o !== 64'd0 || stat_ok_o !== '0 || stat_fail_o !== '0) begin
         errors++;
         $display("FAIL rst_data_stats: got d=%h ok=%0d fl=%0d expected 0 0 0", m_data_o, stat_ok_o, stat_fail_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single_line();
      m_ready_i = 1'b1;
      send_line(64'h8000_0000_0000_0000, 1'b0);
      chk1("single_no_early_valid", m_valid_o, 1'b0);
      chk1("single_busy", busy_o, 1'b1);
      tick();
      chk1("single_latency", m_valid_o, 1'b1);
      drain_check("single", 64'h8000_0000_0000_0000, 64'd0, 1, 1'b0);
      chk1("single_busy_after", busy_o, 1'b0);
   endtask

   task automatic test_failed_line();
      bit seen_valid;
      m_ready_i = 1'b1;
      send_line(64'hF000_0000_0000_0000, 1'b1);
      chk1("fail_pulse", line_fail_o, 1'b1);
      tick();
      chk1("fail_pulse_end", line_fail_o, 1'b0);
      seen_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (m_valid_o !== 1'b0) seen_valid = 1'b1;
         tick();
      end
      chk1("fail_no_valid", seen_valid, 1'b0);
      chk1("fail_busy", busy_o, 1'b0);
      chk1("fail_no_ovf", ovf_o, 1'b0);
   endtask

   task automatic test_backpressure();
      m_ready_i = 1'b0;
      send_line(64'h1111_0000_0000_0000, 1'b0);
      tick();
      drain_check("bp", 64'h1111_0000_0000_0000, 64'd0, 1, 1'b1);
   endtask

   task automatic test_overflow();
      m_ready_i = 1'b0;
      send_line(64'hA000_0000_0000_0000, 1'b0);
      send_line(64'hB000_0000_0000_0000, 1'b0);
      chk1("ovf_before_c", ovf_o, 1'b0);
      send_line(64'hC000_0000_0000_0000, 1'b0);
      chk1("ovf_set", ovf_o, 1'b1);
      chk1("ovf_no_fail_pulse", line_fail_o, 1'b0);
      chk1("ovf_busy", busy_o, 1'b1);
      drain_check("ovf_drain", 64'hA000_0000_0000_0000, 64'hB000_0000_0000_0000, 2, 1'b0);
      chk1("ovf_sticky", ovf_o, 1'b1);
      chk1("ovf_busy_after", busy_o, 1'b0);
   endtask

   task automatic test_reset_mid_drain();
      m_ready_i = 1'b1;
      send_line(64'h5000_0000_0000_0000, 1'b0);
      tick();
      tick();
      tick();
      tick();
      checks++;
      if (m_valid_o !== 1'b1 || m_data_o !== 64'h5000_0000_0000_0003) begin
         errors++;
         $display("FAIL midrst_beat3: got v=%b d=%h expected v=1 d=5000000000000003", m_valid_o, m_data_o);
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("midrst_valid", m_valid_o, 1'b0);
      chk1("midrst_ovf", ovf_o, 1'b0);
      chk1("midrst_busy", busy_o, 1'b0);
      checks++;
      if (m_data_o !== 64'd0 || m_sop_o !== 1'b0 || m_eop_o !== 1'b0) begin
         errors++;
         $display("FAIL midrst_outputs: got d=%h s=%b e=%b expected 0", m_data_o, m_sop_o, m_eop_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      send_line(64'h6000_0000_0000_0000, 1'b0);
      tick();
      chk1("midrst_fresh_latency", m_valid_o, 1'b1);
      drain_check("midrst_fresh", 64'h6000_0000_0000_0000, 64'd0, 1, 1'b0);
   endtask

   task automatic test_stats();
      logic [STAT_W-1:0] exp_ok;
      logic [STAT_W-1:0] exp_fail;
`ifdef AIDC_LITE_COMP_OBUF_STAT_EN
      exp_ok   = 16'd2;
      exp_fail = 16'd2;
`else
      exp_ok   = 16'd0;
      exp_fail = 16'd0;
`endif
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      m_ready_i = 1'b0;
      send_line(64'h2A00_0000_0000_0000, 1'b0);
      send_line(64'h2F00_0000_0000_0000, 1'b1);
      send_line(64'h2B00_0000_0000_0000, 1'b0);
      send_line(64'h2D00_0000_0000_0000, 1'b0);
      tick();
      chk1("stats_ovf", ovf_o, 1'b1);
      checks++;
      if (stat_ok_o !== exp_ok || stat_fail_o !== exp_fail) begin
         errors++;
         $display("FAIL stats: got ok=%0d fail=%0d expected ok=%0d fail=%0d", stat_ok_o, stat_fail_o, exp_ok, exp_fail);
      end
      drain_check("stats_drain", 64'h2A00_0000_0000_0000, 64'h2B00_0000_0000_0000, 2, 1'b0);
   endtask

   initial begin
      test_reset();
      test_single_line();
      test_failed_line();
      test_backpressure();
      test_overflow();
      test_reset_mid_drain();
      test_stats();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
